// File: rtl/inst_fetch_queue.sv
// ============================================================================
// inst_fetch_queue
// ----------------------------------------------------------------------------
// Purpose:
//   FIFO of fetched MIPS instruction words, each tagged with its PC, sitting
//   between instruction fetch and decode. Valid/ready handshakes on both
//   sides decouple fetch stalls from decode stalls. The head entry is
//   presented both as a raw word and pre-split into the MIPS fields. A
//   synchronous flush discards every entry (branch redirect, exception).
//
// Optional build macro:
//   INST_FETCH_QUEUE_BYPASS_EN - when defined, an empty queue forwards an
//   incoming word straight to the head outputs in the same cycle. If decode
//   takes it that cycle the word is never written into storage.
//
// Parameters:
//   DEPTH  - number of entries (power of two, >= 2)
//   PC_W   - width of the PC tag stored with each word
//   INST_W - instruction word width (32 for the MIPS field layout)
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   flush               - synchronous discard of all entries (beats push/pop)
//   in_valid/in_ready   - fetch-side handshake; in_ready depends only on count
//   in_inst, in_pc      - word offered by fetch and its PC
//   out_valid/out_ready - decode-side handshake
//   out_inst, out_pc    - head word and PC (0 while out_valid=0)
//   op..j_index         - MIPS fields sliced from out_inst
//   count               - number of occupied entries
// ============================================================================
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic [5:0]                 op,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [5:0]                 funct,
    output logic [15:0]                imm,
    output logic [25:0]                j_index,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Storage is deliberately left unreset; count/pointers alone say what is live.
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;

    logic              stored_valid;
    logic              head_valid;
    logic              write_en;
    logic              read_en;
    logic [INST_W-1:0] head_inst;
    logic [PC_W-1:0]   head_pc;

    // in_ready looks only at registered occupancy, so a full queue refuses a
    // push even when decode pops in the same cycle (no ready->ready path).
    assign in_ready     = (count_q != FULL_COUNT);
    assign stored_valid = (count_q != '0);

`ifdef INST_FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // Empty queue with a word arriving: show it at the head right away. If
    // decode accepts it now, it is consumed without ever touching storage.
    assign bypass     = ~stored_valid & ~flush & in_valid;
    assign head_valid = stored_valid | bypass;
    assign head_inst  = bypass ? in_inst : mem_inst[rd_ptr];
    assign head_pc    = bypass ? in_pc   : mem_pc[rd_ptr];
    assign write_en   = in_valid & in_ready & ~flush & ~(bypass & out_ready);
`else
    assign head_valid = stored_valid;
    assign head_inst  = mem_inst[rd_ptr];
    assign head_pc    = mem_pc[rd_ptr];
    assign write_en   = in_valid & in_ready & ~flush;
`endif

    // Only stored entries advance the read pointer; a bypassed word never
    // occupied a slot.
    assign read_en = stored_valid & out_ready & ~flush;

    // Pointer and occupancy bookkeeping. Flush wins over any transfer; the
    // pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (read_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({write_en, read_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_inst[wr_ptr] <= in_inst;
            mem_pc[wr_ptr]   <= in_pc;
        end
    end

    // Head outputs read as zero whenever nothing valid is presented.
    assign out_valid = head_valid;
    assign out_inst  = head_valid ? head_inst : '0;
    assign out_pc    = head_valid ? head_pc   : '0;
    assign count     = count_q;

    assign op      = out_inst[31:26];
    assign rs      = out_inst[25:21];
    assign rt      = out_inst[20:16];
    assign rd      = out_inst[15:11];
    assign shamt   = out_inst[10:6];
    assign funct   = out_inst[5:0];
    assign imm     = out_inst[15:0];
    assign j_index = out_inst[25:0];

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parametrised successor to the combinational instruction field splitter.
- Buffers up to DEPTH fetched MIPS instruction words, each with its PC, in a FIFO with valid/ready handshakes on both sides.
- Presents the head entry already split into op/rs/rt/rd/shamt/funct/imm/j_index.
- Sits between instruction fetch and decode; decouples fetch stalls from decode stalls and supports pipeline flush.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PC_W, 32, width of the PC tag stored with each instruction.
- INST_W, 32, instruction word width; fixed at 32 for the MIPS field layout, present for width checks only.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all entries.
- in_valid  input  1  fetch offers a word.
- in_ready  output  1  queue accepts a word.
- in_inst  input  32  instruction word.
- in_pc  input  PC_W  PC of in_inst.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode consumes head.
- out_inst  output  32  head instruction word.
- out_pc  output  PC_W  head PC.
- op  output  6  out_inst[31:26].
- rs  output  5  out_inst[25:21].
- rt  output  5  out_inst[20:16].
- rd  output  5  out_inst[15:11].
- shamt  output  5  out_inst[10:6].
- funct  output  6  out_inst[5:0].
- imm  output  16  out_inst[15:0].
- j_index  output  26  out_inst[25:0].
- count  output  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (asynchronous, active-high): read pointer, write pointer and count go to 0; out_valid=0; in_ready=1. Every data/field output reads 0 while out_valid=0. Storage array is not reset.
- push = in_valid & in_ready. pop = out_valid & out_ready. Both are sampled on the rising clk edge.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready. When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0). Head fields come from the entry at the read pointer.
- Latency: a pushed word appears at the head on the cycle after the push edge when the queue was empty. Minimum latency is 1 cycle.
- Push only: write entry at write pointer, write pointer +1 modulo DEPTH, count +1.
- Pop only: read pointer +1 modulo DEPTH, count -1.
- Push and pop in the same cycle: both pointers advance, count unchanged, FIFO order preserved.
- Pointers wrap naturally at DEPTH because DEPTH is a power of two.
- flush=1 at an edge: pointers and count go to 0 and any push or pop that cycle is ignored. flush has priority over push and pop. in_ready stays combinational from count, so it may be 1 during the flush cycle, but the word is dropped.
- Reset during a transfer: all entries are lost and the queue restarts empty.
- Field outputs are pure slices of out_inst and are gated to 0 when out_valid=0. Outputs hold stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: INST_FETCH_QUEUE_BYPASS_EN.
- With the macro defined:
  - When count==0, flush=0 and in_valid=1, out_valid=1 in the same cycle and out_inst/out_pc/fields are driven combinationally from in_inst/in_pc.
  - If out_ready=1 in that cycle, the word is consumed and not written; count stays 0.
  - If out_ready=0, the word is stored normally.
- Without the macro: no combinational path from the in_* ports to the out_* ports; minimum latency is 1 cycle.

Test Plan:
- Reset mid-stream with 3 entries held -> count=0, out_valid=0, in_ready=1, op..j_index all 0 immediately, without waiting for an edge.
- DEPTH=4; push 0x8C430004 at pc 0x00400000 with out_ready=0 -> next cycle out_valid=1, op=0x23, rs=2, rt=3, imm=0x0004, out_pc=0x00400000.
- Push 4 words with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is refused. Pop 4 -> words come out in push order, then out_valid=0.
- Hold count=2; run simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap, no word lost or duplicated.
- count=3, then flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, pushed word absent.
- With BYPASS_EN on an empty queue, in_valid=1 and out_ready=1 with 0x08100000 -> same cycle out_valid=1, op=2, j_index=0x0100000, count stays 0. Without the macro -> out_valid=0 that cycle.
